// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow external square wave in system-clock
// cycles, with back-to-back reporting and a stall timeout.
module clk_period_meter #(
  parameter int unsigned      CNT_W   = 28,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd100_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Input path: two-flop synchronizer plus one history flop.
  logic sync1_q, s_sync_q, s_prev_q;
  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hts_q, hts_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_pend_q, valid_pend_d;
  logic             meas_valid_q;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  assign rise = s_sync_q & ~s_prev_q;
  assign fall = ~s_sync_q & s_prev_q;

  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hts_d        = hts_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    valid_pend_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (meas_en) begin
          state_d = WAIT_LOW;
          cnt_d   = ONE;
        end
      end
      // Insist on seeing the input low first so the arming rise is genuine.
      WAIT_LOW: begin
        if (!s_sync_q) begin
          state_d = WAIT_RISE;
          cnt_d   = ONE;
        end else if (cnt_q == TIMEOUT) begin
          timeout_d = 1'b1;
          cnt_d     = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
          hts_d   = '0;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = WAIT_LOW;
          timeout_d = 1'b1;
          cnt_d     = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d     = cnt_q;
          high_time_d  = hts_q;
          valid_pend_d = 1'b1;
          cnt_d        = ONE;
          hts_d        = '0;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = WAIT_LOW;
          timeout_d = 1'b1;
          cnt_d     = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (fall) hts_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable overrides everything below reset; a partial measurement is dropped.
    if (!meas_en) begin
      state_d      = IDLE;
      cnt_d        = '0;
      hts_d        = hts_q;
      period_d     = period_q;
      high_time_d  = high_time_q;
      valid_pend_d = 1'b0;
      timeout_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      sync1_q      <= 1'b0;
      s_sync_q     <= 1'b0;
      s_prev_q     <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      hts_q        <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      valid_pend_q <= 1'b0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sig_in;
      s_sync_q     <= sync1_q;
      s_prev_q     <= s_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hts_q        <= hts_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      valid_pend_q <= valid_pend_d;
      meas_valid_q <= valid_pend_q;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: square-wave segments are generated,
// expected reports are queued from segment lengths, a monitor checks outputs.
module tb_clk_period_meter;

  localparam int unsigned CNT_W = 8;
  localparam int          TO    = 64;

  logic             clk_in  = 1'b0;
  logic             rst     = 1'b1;
  logic             sig_in  = 1'b0;
  logic             meas_en = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, timeout, busy;

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (8'd64)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_en    (meas_en),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    int h;
    int gap;
  } rep_t;

  rep_t exp_q[$];
  int   seg_h[$];
  int   seg_l[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   to_issued = 0;
  int   to_seen   = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   last_p = 0;
  int   last_h = 0;
  bit   prev_valid = 1'b0;
  bit   prev_to = 1'b0;
  bit   armed = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk_in) cyc++;

  // Monitor: pops the scoreboard whenever the DUT presents a report or timeout.
  always @(negedge clk_in) begin
    if (rst === 1'b1) begin
      last_p = 0;
      last_h = 0;
    end
    if (meas_valid === 1'b1) begin
      check("valid_timeout_exclusive", 32'(timeout), 0);
      check("valid_one_cycle", 32'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(meas_valid), 0);
      end else begin
        rep_t e;
        e = exp_q.pop_front();
        check("period", 32'(period), e.p);
        check("high_time", 32'(high_time), e.h);
        if (e.gap != 0) check("valid_spacing", cyc - last_cyc, e.gap);
        last_p = e.p;
        last_h = e.h;
      end
      last_cyc = cyc;
    end
    if (timeout === 1'b1) begin
      check("timeout_one_cycle", 32'(prev_to), 0);
      if (to_seen >= to_issued) begin
        check("spurious_timeout", 32'(timeout), 0);
      end else begin
        check("timeout_period_hold", 32'(period), last_p);
        check("timeout_high_hold", 32'(high_time), last_h);
      end
      to_seen++;
    end
    prev_valid = (meas_valid === 1'b1);
    prev_to    = (timeout === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Reference model: a rise ends the previous segment; it reports if the
  // period fits within TIMEOUT, otherwise the meter times out and disarms.
  function automatic void push_period(input int h, input int l, input bit first);
    rep_t r;
    if (!armed) return;
    if (h + l <= TO) begin
      r.p   = h + l;
      r.h   = h;
      r.gap = first ? 0 : h + l;
      exp_q.push_back(r);
    end else begin
      to_issued++;
      armed = 1'b0;
    end
  endfunction

  // mode 0 ends with meas_en dropped mid-measurement, mode 1 with rst.
  task automatic run(input int pre_high, input int stuck, input int mode);
    if (pre_high > 0) begin
      sig_in = 1'b1;
      cycles(3);
      meas_en = 1'b1;
      cycles(pre_high);
      sig_in = 1'b0;
      cycles(5);
    end else begin
      sig_in = 1'b0;
      cycles(3);
      meas_en = 1'b1;
      cycles(4);
    end
    armed = 1'b1;
    for (int i = 0; i < seg_h.size(); i++) begin
      sig_in = 1'b1;
      if (i > 0) push_period(seg_h[i-1], seg_l[i-1], i == 1);
      cycles(seg_h[i]);
      sig_in = 1'b0;
      cycles(seg_l[i]);
    end
    sig_in = 1'b1;
    push_period(seg_h[seg_h.size()-1], seg_l[seg_l.size()-1], seg_h.size() == 1);
    cycles(3);
    sig_in = 1'b0;
    cycles(5);
    if (stuck > 0) begin
      if (armed) to_issued++;
      cycles(stuck);
      check("busy_after_timeout", 32'(busy), 1);
    end
    check("reports_drained", exp_q.size(), 0);
    check("timeouts_seen", to_seen, to_issued);
    if (mode == 0) begin
      meas_en = 1'b0;
      cycles(1);
      check("abort_busy", 32'(busy), 0);
      check("abort_period_hold", 32'(period), last_p);
      check("abort_high_hold", 32'(high_time), last_h);
    end else begin
      rst     = 1'b1;
      meas_en = 1'b0;
      cycles(1);
      check("rst_period", 32'(period), 0);
      check("rst_high_time", 32'(high_time), 0);
      check("rst_valid", 32'(meas_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_busy", 32'(busy), 0);
      cycles(1);
      rst = 1'b0;
    end
    // Activity while disabled must never produce a report.
    for (int k = 0; k < 4; k++) begin
      sig_in = 1'b1;
      cycles(2);
      sig_in = 1'b0;
      cycles(3);
    end
    seg_h.delete();
    seg_l.delete();
  endtask

  task automatic add_segs(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      seg_h.push_back(h);
      seg_l.push_back(l);
    end
  endtask

  initial begin
    cycles(3);
    check("reset_period", 32'(period), 0);
    check("reset_high_time", 32'(high_time), 0);
    check("reset_valid", 32'(meas_valid), 0);
    check("reset_timeout", 32'(timeout), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    cycles(2);

    add_segs(4, 6, 5);     // steady 4/6 wave
    run(0, 0, 0);
    add_segs(3, 7, 3);     // high at enable, then 3/7
    run(5, 0, 0);
    add_segs(5, 5, 2);     // stuck low after arming
    run(0, 100, 0);
    add_segs(32, 32, 2);   // period exactly TIMEOUT
    run(0, 0, 0);
    add_segs(33, 32, 1);   // period TIMEOUT+1
    run(0, 0, 0);
    add_segs(6, 4, 2);     // reset mid-measurement
    run(0, 0, 1);
    add_segs(4, 6, 3);     // re-enable after reset
    run(7, 0, 0);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(3, 7));
      for (int i = 0; i < n; i++) begin
        int h, l;
        h = int'($urandom_range(1, 40));
        l = int'($urandom_range(1, TO - h));
        seg_h.push_back(h);
        seg_l.push_back(l);
      end
      run(int'($urandom_range(0, 8)), 0, r % 2);
    end

    cycles(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
